// File: rtl/ps2_pkg.sv
// Shared PS/2 device-side constants, FSM state type and byte-sequence helpers.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam logic [7:0] PS2_BRK        = 8'hF0;
   localparam int         PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {ST_IDLE, ST_SEND_H, ST_SEND_L} tx_state_e;

   // b[0] is the first byte to enqueue; n is how many of b[] are valid
   typedef struct packed {
      logic [1:0]      n;
      logic [2:0][7:0] b;
   } key_seq_t;

   function automatic key_seq_t key_to_seq(input logic [9:0] k);
      key_seq_t s;
      case ({k[8], ~k[9]})
         2'b00:   begin s.n = 2'd1; s.b = {8'h00, 8'h00, k[7:0]};     end
         2'b10:   begin s.n = 2'd2; s.b = {8'h00, k[7:0], PS2_EXT};   end
         2'b01:   begin s.n = 2'd2; s.b = {8'h00, k[7:0], PS2_BRK};   end
         default: begin s.n = 2'd3; s.b = {k[7:0], PS2_BRK, PS2_EXT}; end
      endcase
      return s;
   endfunction

   // {stop, odd parity, data, start}; bit 0 goes out first
   function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO; pointers wrap naturally at 2^FIFO_AW.
module ps2_byte_fifo #(
   parameter int FIFO_AW = 3
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               push,
   input  logic [7:0]         din,
   input  logic               pop,
   output logic [7:0]         dout,
   output logic [FIFO_AW:0]   count
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic               do_push, do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != (FIFO_AW+1)'(DEPTH)) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2_key_tx.sv
// Turns key toggle events into PS/2 scan-code bytes and transmits them
// device-side, backing off whenever the host holds the clock line low.
module ps2_key_tx
   import ps2_pkg::*;
#(
   parameter int CLK_DIV = 3360,
   parameter int HOLDOFF = 6720,
   parameter int FIFO_AW = 3
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic        ps2_clk_in,
   output logic        ps2_clk_out,
   output logic        ps2_dat_out,
   output logic        busy,
   output logic        overflow
);

   localparam int DEPTH  = 1 << FIFO_AW;
   localparam int CW     = FIFO_AW + 1;
   localparam int DIV_W  = $clog2(CLK_DIV + 1);
   localparam int HOLD_W = $clog2(HOLDOFF + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

   // ---------------- event capture and byte enqueue ----------------
   logic            tog_q, evt;
   logic            pend_vld;
   logic [9:0]      pend_key;
   key_seq_t        pend_seq;
   logic [1:0]      emit_cnt;
   logic [2:0][7:0] emit_b;
   logic            can_start, fits;
   logic [CW:0]     occ_next;

   logic            push, pop;
   logic [7:0]      dout;
   logic [CW-1:0]   count;

   assign evt       = ps2_key[10] != tog_q;
   assign pend_seq  = key_to_seq(pend_key);
   assign push      = emit_cnt != 2'd0;
   // occupancy as it will stand next cycle, so a new event can start on the
   // last byte of the previous one without risking a partial enqueue
   assign occ_next  = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
   assign fits      = (occ_next + (CW+1)'(pend_seq.n)) <= (CW+1)'(DEPTH);
   assign can_start = pend_vld && (emit_cnt <= 2'd1);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tog_q    <= ps2_key[10];
         pend_vld <= 1'b0;
         pend_key <= '0;
         emit_cnt <= 2'd0;
         emit_b   <= '0;
         overflow <= 1'b0;
      end else begin
         tog_q <= ps2_key[10];
         if (emit_cnt != 2'd0) begin
            emit_b   <= {8'h00, emit_b[2:1]};
            emit_cnt <= emit_cnt - 2'd1;
         end
         if (can_start) begin
            if (fits) begin
               emit_b   <= pend_seq.b;
               emit_cnt <= pend_seq.n;
            end else begin
               overflow <= 1'b1;
            end
         end
         if (evt && (!pend_vld || can_start)) begin
            pend_key <= ps2_key[9:0];
            pend_vld <= 1'b1;
         end else begin
            if (evt) overflow <= 1'b1;
            if (can_start) pend_vld <= 1'b0;
         end
      end
   end

   ps2_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (push),
      .din     (emit_b[0]),
      .pop     (pop),
      .dout    (dout),
      .count   (count)
   );

   // ---------------- frame transmitter ----------------
   tx_state_e                 state, state_n;
   logic [DIV_W-1:0]          div_cnt, div_n;
   logic [HOLD_W-1:0]         hold_cnt, hold_n;
   logic [3:0]                bit_idx, bit_n;
   logic [PS2_FRAME_BITS-1:0] shreg, shreg_n;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state    <= ST_IDLE;
         div_cnt  <= '0;
         hold_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '1;
      end else begin
         state    <= state_n;
         div_cnt  <= div_n;
         hold_cnt <= hold_n;
         bit_idx  <= bit_n;
         shreg    <= shreg_n;
      end
   end

   always_comb begin
      state_n = state;
      div_n   = div_cnt;
      hold_n  = hold_cnt;
      bit_n   = bit_idx;
      shreg_n = shreg;
      pop     = 1'b0;
      case (state)
         ST_IDLE: begin
            div_n = '0;
            bit_n = '0;
            if (count == '0 || !ps2_clk_in) begin
               hold_n = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               hold_n  = '0;
               shreg_n = ps2_frame(dout);
               state_n = ST_SEND_H;
            end else begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         ST_SEND_H: begin
            if (div_cnt == DIV_LAST) begin
               div_n = '0;
               // host inhibit: head stays queued and is resent whole later
               state_n = ps2_clk_in ? ST_SEND_L : ST_IDLE;
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         ST_SEND_L: begin
            if (div_cnt == DIV_LAST) begin
               div_n   = '0;
               shreg_n = {1'b1, shreg[PS2_FRAME_BITS-1:1]};
               if (bit_idx == 4'(PS2_FRAME_BITS - 1)) begin
                  pop     = 1'b1;
                  state_n = ST_IDLE;
               end else begin
                  bit_n   = bit_idx + 1'b1;
                  state_n = ST_SEND_H;
               end
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign ps2_clk_out = state != ST_SEND_L;
   assign ps2_dat_out = (state == ST_IDLE) ? 1'b1 : shreg[0];
   assign busy        = (state != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_ps2_key_tx.sv
// Directed bench: frames are captured at each falling ps2_clk_out edge and
// compared against hand-computed 11-bit frames {stop, parity, data, start}.
module tb_ps2_key_tx;

   localparam int CLK_DIV = 4;
   localparam int HOLDOFF = 8;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic        ps2_clk_in;
   logic        ps2_clk_out, ps2_dat_out, busy, overflow;

   int n_vec = 0;
   int n_err = 0;

   ps2_key_tx #(.CLK_DIV(CLK_DIV), .HOLDOFF(HOLDOFF), .FIFO_AW(3)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ps2_key     (ps2_key),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_clk_out (ps2_clk_out),
      .ps2_dat_out (ps2_dat_out),
      .busy        (busy),
      .overflow    (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // ---------------- line monitor ----------------
   logic [10:0] frm_q[$];
   int          gap_q[$];
   int          len_q[$];
   int          cyc = 0;
   int          nb = 0;
   int          t_first = 0;
   int          t_end = 0;
   logic [10:0] sh = '0;
   logic        clk_prev = 1'b1;

   always @(posedge clk_sys) cyc <= cyc + 1;

   initial forever begin
      @(negedge clk_sys);
      if (clk_prev && !ps2_clk_out) begin
         sh[nb] = ps2_dat_out;
         if (nb == 0) t_first = cyc;
         nb++;
         if (nb == 11) begin
            frm_q.push_back(sh);
            gap_q.push_back(t_first - t_end);
            len_q.push_back(cyc - t_first);
            t_end = cyc;
            nb    = 0;
         end
      end
      clk_prev = ps2_clk_out;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic toggle(input logic pressed, input logic ext, input logic [7:0] code);
      ps2_key = {~ps2_key[10], pressed, ext, code};
      tick(1);
   endtask

   task automatic wait_frames(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && frm_q.size() < n; i++) tick(1);
      chk(tag, frm_q.size(), n);
   endtask

   task automatic wait_bits(input string tag, input int n);
      int i;
      i = 0;
      while (!(nb == n && ps2_clk_out) && i < 1000) begin
         tick(1);
         i++;
      end
      chk(tag, (i < 1000), 1);
   endtask

   task automatic chk_frm(input string tag, input logic [10:0] exp, output int gap, output int len);
      logic [10:0] f;
      f = '0; gap = 0; len = 0;
      if (frm_q.size() > 0) begin
         f   = frm_q.pop_front();
         gap = gap_q.pop_front();
         len = len_q.pop_front();
      end
      chk(tag, f, exp);
   endtask

   task automatic wait_idle(input string tag);
      int i;
      i = 0;
      while (busy && i < 3000) begin
         tick(1);
         i++;
      end
      chk(tag, busy, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int gap, len, bad;
      reset      = 1'b1;
      ps2_key    = {1'b1, 1'b0, 1'b0, 8'h00};
      ps2_clk_in = 1'b1;
      tick(3);
      chk("rst_clk", ps2_clk_out, 1'b1);
      chk("rst_dat", ps2_dat_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      reset = 1'b0;
      tick(40);
      chk("no_spurious_busy", busy, 1'b0);
      chk("no_spurious_frm", frm_q.size(), 0);

      // make 0x1C: data 0,0,1,1,1,0,0,0 parity 0
      toggle(1'b1, 1'b0, 8'h1C);
      wait_frames("make1c_cnt", 1, 500);
      chk_frm("make1c_frm", 11'b1_0_00011100_0, gap, len);
      chk("frame_len", len, 20 * CLK_DIV);
      wait_idle("make1c_idle");
      tick(30);
      chk("make1c_only", frm_q.size(), 0);

      // extended release of 0x75: E0 F0 75, parity 0,1,0
      toggle(1'b0, 1'b1, 8'h75);
      wait_frames("brk75_cnt", 3, 1000);
      chk_frm("brk75_e0", 11'b1_0_11100000_0, gap, len);
      chk_frm("brk75_f0", 11'b1_1_11110000_0, gap, len);
      chk("gap_e0_f0", gap >= (HOLDOFF + 2 * CLK_DIV), 1);
      chk_frm("brk75_75", 11'b1_0_01110101_0, gap, len);
      chk("gap_f0_75", gap >= (HOLDOFF + 2 * CLK_DIV), 1);
      wait_idle("brk75_idle");

      // four 3-byte events with the host holding clock low: only two fit
      ps2_clk_in = 1'b0;
      toggle(1'b0, 1'b1, 8'h11); tick(3);
      toggle(1'b0, 1'b1, 8'h22); tick(3);
      toggle(1'b0, 1'b1, 8'h33); tick(3);
      toggle(1'b0, 1'b1, 8'h44); tick(6);
      chk("ovf_flag", overflow, 1'b1);
      chk("ovf_fifo_cnt", dut.u_fifo.count, 6);
      chk("ovf_held_busy", busy, 1'b1);
      chk("ovf_held_nofrm", frm_q.size(), 0);
      ps2_clk_in = 1'b1;
      wait_frames("ovf_cnt", 6, 2000);
      chk_frm("ovf_e0a", 11'b1_0_11100000_0, gap, len);
      chk_frm("ovf_f0a", 11'b1_1_11110000_0, gap, len);
      chk_frm("ovf_11",  11'b1_1_00010001_0, gap, len);
      chk_frm("ovf_e0b", 11'b1_0_11100000_0, gap, len);
      chk_frm("ovf_f0b", 11'b1_1_11110000_0, gap, len);
      chk_frm("ovf_22",  11'b1_1_00100010_0, gap, len);
      wait_idle("ovf_idle");
      tick(40);
      chk("ovf_no_extra", frm_q.size(), 0);
      chk("ovf_sticky", overflow, 1'b1);

      // host inhibit during SEND_H of bit 5 (data bit 4 of 0x4A is 0)
      toggle(1'b1, 1'b0, 8'h4A);
      wait_bits("inh_reach_b5", 5);
      chk("inh_b5_dat", ps2_dat_out, 1'b0);
      ps2_clk_in = 1'b0;
      tick(CLK_DIV);
      chk("inh_rel_clk", ps2_clk_out, 1'b1);
      chk("inh_rel_dat", ps2_dat_out, 1'b1);
      bad = 0;
      for (int i = 0; i < 3 * CLK_DIV; i++) begin
         tick(1);
         if (!ps2_clk_out || !ps2_dat_out) bad++;
      end
      chk("inh_stay_rel", bad, 0);
      chk("inh_busy", busy, 1'b1);
      nb = 0;
      ps2_clk_in = 1'b1;
      wait_frames("inh_cnt", 1, 500);
      chk_frm("inh_resend", 11'b1_0_01001010_0, gap, len);
      wait_idle("inh_idle");
      tick(30);
      chk("inh_once", frm_q.size(), 0);

      // new event arriving mid-frame follows the current frame
      toggle(1'b1, 1'b0, 8'h1C);
      wait_bits("mid_reach_b3", 3);
      toggle(1'b0, 1'b0, 8'h16);
      wait_frames("mid_cnt", 3, 1000);
      chk_frm("mid_1c", 11'b1_0_00011100_0, gap, len);
      chk_frm("mid_f0", 11'b1_1_11110000_0, gap, len);
      chk_frm("mid_16", 11'b1_0_00010110_0, gap, len);
      wait_idle("mid_idle");

      // reset during bit 3 discards the byte
      toggle(1'b1, 1'b0, 8'h29);
      wait_bits("rstmid_reach_b3", 3);
      reset = 1'b1;
      tick(1);
      chk("rstmid_clk", ps2_clk_out, 1'b1);
      chk("rstmid_dat", ps2_dat_out, 1'b1);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_fifo", dut.u_fifo.count, 0);
      chk("rstmid_ovf", overflow, 1'b0);
      reset = 1'b0;
      nb = 0;
      tick(200);
      chk("rstmid_nofrm", frm_q.size(), 0);
      chk("rstmid_nobits", nb, 0);
      chk("rstmid_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
